// File: rtl/fir_pkg.sv
// Shared widths, coefficient table, term arithmetic and FSM encoding for the
// time-multiplexed 25-tap FIR.
package fir_pkg;

    localparam int TAPS     = 25;
    localparam int X_W      = 19;
    localparam int H_W      = 18;
    localparam int P_W      = 37;
    localparam int ACC_W    = 22;
    localparam int Y_W      = 20;
    localparam int TAP_W    = $clog2(TAPS);
    localparam int TERM_MSB = 34;
    localparam int TERM_LSB = 14;

    typedef logic signed [X_W-1:0]   sample_t;
    typedef logic signed [H_W-1:0]   coef_t;
    typedef logic signed [P_W-1:0]   product_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [Y_W-1:0]   y_t;
    typedef logic [TAP_W-1:0]        tap_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Symmetric table: h[i] == h[24-i]; only defined for a 25-tap filter.
    function automatic coef_t coef_at(input tap_t idx);
        coef_t h;
        h = '0;
        case (idx)
            5'd1,  5'd23: h = 18'sd3346;
            5'd2,  5'd22: h = 18'sd5676;
            5'd3,  5'd21: h = 18'sd4815;
            5'd4,  5'd20: h = -18'sd1;
            5'd5,  5'd19: h = -18'sd7017;
            5'd6,  5'd18: h = -18'sd12165;
            5'd7,  5'd17: h = -18'sd10759;
            5'd9,  5'd15: h = 18'sd19029;
            5'd10, 5'd14: h = 18'sd41115;
            5'd11, 5'd13: h = 18'sd58787;
            5'd12:        h = 18'sd65536;
            default:      h = '0;
        endcase
        return h;
    endfunction

    function automatic acc_t mac_term(input sample_t x, input coef_t h);
        product_t p;
        p = product_t'(x) * product_t'(h);
        return acc_t'(signed'(p[TERM_MSB:TERM_LSB]));
    endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample-in / result-out handshake bundle for fir_serial_mac.
interface fir_serial_mac_if;

    logic             in_valid;
    logic             in_ready;
    fir_pkg::sample_t input_x;
    logic             out_valid;
    logic             out_ready;
    fir_pkg::y_t      output_y;

    modport master (
        output in_valid,
        output input_x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  output_y
    );

    modport slave (
        input  in_valid,
        input  input_x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output output_y
    );

endinterface

// File: rtl/fir_sample_buf.sv
// Circular sample history: one write port at the write pointer, one read port
// returning x[n-i] for tap i, cleared by reset.
module fir_sample_buf
    import fir_pkg::*;
#(
    parameter int DEPTH = TAPS
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_wr_en,
    input  sample_t i_wr_data,
    input  logic    i_advance,
    input  tap_t    i_rd_tap,
    output sample_t o_rd_data
);

    sample_t r_hist [DEPTH];
    tap_t    r_wptr;
    tap_t    w_rd_addr;

    // (write pointer - tap) mod DEPTH without a divider.
    always_comb begin
        if (r_wptr >= i_rd_tap) begin
            w_rd_addr = r_wptr - i_rd_tap;
        end else begin
            w_rd_addr = r_wptr + tap_t'(DEPTH) - i_rd_tap;
        end
    end

    assign o_rd_data = r_hist[w_rd_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            // NOTE: the history is cleared on reset because later outputs must
            // assume zero prior samples; this keeps it in flops, not RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_hist[r_wptr] <= i_wr_data;
            end
            if (i_advance) begin
                r_wptr <= (r_wptr == tap_t'(DEPTH - 1)) ? '0 : r_wptr + tap_t'(1);
            end
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// 25-tap FIR with one shared multiplier: accepts a sample, spends 25 cycles
// accumulating taps, then holds the result until downstream takes it.
module fir_serial_mac
    import fir_pkg::state_t, fir_pkg::ST_IDLE, fir_pkg::ST_MAC, fir_pkg::ST_HOLD,
           fir_pkg::sample_t, fir_pkg::acc_t, fir_pkg::y_t, fir_pkg::tap_t,
           fir_pkg::ACC_W, fir_pkg::coef_at, fir_pkg::mac_term;
#(
    parameter int TAPS = fir_pkg::TAPS
)
(
    input  logic           clk,
    input  logic           rst,
    fir_serial_mac_if.slave bus
);

    state_t  r_state;
    state_t  w_state_nxt;
    acc_t    r_acc;
    acc_t    w_acc_nxt;
    tap_t    r_tap;
    tap_t    w_tap_nxt;
    y_t      r_y;
    y_t      w_y_nxt;
    logic    r_out_valid;
    logic    w_out_valid_nxt;
    logic    w_in_ready;
    logic    w_wr_en;
    logic    w_advance;
    sample_t w_hist_x;
    acc_t    w_term;

    // The pointer advances only once the last tap is read, so during MAC the
    // current sample sits exactly at the write pointer.
    fir_sample_buf #(
        .DEPTH (TAPS)
    ) u_sample_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (bus.input_x),
        .i_advance (w_advance),
        .i_rd_tap  (r_tap),
        .o_rd_data (w_hist_x)
    );

    assign w_term = mac_term(w_hist_x, coef_at(r_tap));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_tap       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed by the combinational block below.
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_tap       <= w_tap_nxt;
            r_y         <= w_y_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_tap_nxt       = r_tap;
        w_y_nxt         = r_y;
        w_out_valid_nxt = r_out_valid;
        w_in_ready      = 1'b0;
        w_wr_en         = 1'b0;
        w_advance       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_wr_en     = 1'b1;
                    w_acc_nxt   = '0;
                    w_tap_nxt   = '0;
                    w_state_nxt = ST_MAC;
                end
            end

            ST_MAC: begin
                w_acc_nxt = r_acc + w_term;
                if (r_tap == tap_t'(TAPS - 1)) begin
                    w_y_nxt         = w_acc_nxt[ACC_W-1:2];
                    w_out_valid_nxt = 1'b1;
                    w_advance       = 1'b1;
                    w_state_nxt     = ST_HOLD;
                end else begin
                    w_tap_nxt = r_tap + tap_t'(1);
                end
            end

            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.output_y  = r_y;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomised scoreboard bench for fir_serial_mac against a plain-arithmetic
// model of the 25-tap filter.
module tb_fir_serial_mac;

    localparam int NTAP = 25;
    localparam int H [NTAP] = '{0, 3346, 5676, 4815, -1, -7017, -12165, -10759, 0,
                                19029, 41115, 58787, 65536, 58787, 41115, 19029, 0,
                                -10759, -12165, -7017, -1, 4815, 5676, 3346, 0};

    typedef struct {
        int y;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ready_mode = 0;
    int   last_exp_y = 0;
    int   hist [NTAP];
    exp_t exp_q [$];

    fir_serial_mac_if bus ();

    fir_serial_mac #(
        .TAPS (NTAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= (m >>> 1)) v = v - m;
        return v;
    endfunction

    function automatic int model_y();
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < NTAP; i++) begin
            p   = longint'(hist[i]) * longint'(H[i]);
            acc = acc + wrap(p >>> 14, 21);
        end
        acc = wrap(acc, 22);
        return int'(acc >>> 2);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NTAP; i++) hist[i] = 0;
        exp_q.delete();
    endfunction

    function automatic void model_push(input int x, input int accept_cyc);
        exp_t e;
        for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]    = x;
        e.y        = model_y();
        e.cyc      = accept_cyc + 25;
        last_exp_y = e.y;
        exp_q.push_back(e);
    endfunction

    function automatic int rand_x();
        int v;
        v = int'($urandom_range(0, 524287));
        if (v >= 262144) v = v - 524288;
        return v;
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev_ov;
        int   cur_y;
        exp_t e;
        prev_ov = 1'b0;
        cur_y   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.out_valid === 1'b1 && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", 1, 0);
                    end else begin
                        e     = exp_q.pop_front();
                        cur_y = e.y;
                        check("output_y", $signed(bus.output_y), e.y);
                        check("latency_cycle", cyc, e.cyc);
                    end
                end
                if (bus.out_valid === 1'b1) begin
                    check("hold_y_stable", $signed(bus.output_y), cur_y);
                    check("hold_in_ready_low", bus.in_ready, 0);
                end
                prev_ov = (bus.out_valid === 1'b1);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input int x, output int accept_cyc);
        int waited;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        accept_cyc = cyc + 1;
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", bus.in_ready, 1);
        end else begin
            bus.in_valid = 1'b1;
            bus.input_x  = x[18:0];
            model_push(x, accept_cyc);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.input_x  = 19'($urandom);
        end
    endtask

    task automatic send_zeros(input int n);
        int a;
        for (int i = 0; i < n; i++) send(0, a);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_in_ready"}, bus.in_ready, 1);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_output_y"}, $signed(bus.output_y), 0);
    endtask

    task automatic do_reset(input string name);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_reset_state(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a;
        int prev_a;
        int waited;
        int corners [7] = '{262143, -262144, -1, 1, 262143, 262143, -262144};

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.input_x  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_reset_state("por");

        // impulse
        send(65536, a);
        send_zeros(30);
        drain("drain_impulse", 200);

        // DC step, back-to-back at full throughput
        prev_a = 0;
        for (int i = 0; i < 30; i++) begin
            send(65536, a);
            if (i > 0) check("throughput_spacing", a - prev_a, 27);
            prev_a = a;
        end
        drain("drain_dc", 200);

        // negative impulse from a cleared history
        do_reset("reset_before_neg");
        send(-65536, a);
        send_zeros(30);
        drain("drain_neg_impulse", 200);

        // backpressure with stray in_valid pulses while holding
        ready_mode = 2;
        send(rand_x(), a);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("bp_out_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.input_x  = 19'($urandom_range(1, 262143));
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_output_y", $signed(bus.output_y), last_exp_y);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        ready_mode   = 0;
        for (int i = 0; i < 3; i++) send(rand_x(), a);
        drain("drain_backpressure", 200);

        // reset while the MAC is at tap 10
        send(65536, a);
        repeat (10) @(negedge clk);
        do_reset("reset_mid_mac");
        send(65536, a);
        send_zeros(30);
        drain("drain_after_abort", 200);

        // randomised samples with random downstream readiness
        ready_mode = 1;
        for (int i = 0; i < 7; i++) send(corners[i], a);
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rand_x(), a);
        end
        drain("drain_random", 400);
        ready_mode = 0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
